// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Word-organised data RAM serving the hart's data-memory port
//             (combinational read, clocked byte-masked write). It also polices
//             the port protocol: illegal cycles have no side effects, and the
//             first violation is held in sticky capture registers until
//             i_err_clr.
//  Ports    : i_clk, i_rst_n (async, active low)
//             i_dmem_addr/ren/wen/wdata/mask -> o_dmem_rdata (combinational)
//             i_err_clr -> o_err, o_err_cause, o_err_addr (sticky capture)
//             o_rd_count/o_wr_count  (only with DMEM_RESPONDER_STATS_EN)
//  Option   : `define DMEM_RESPONDER_STATS_EN adds legal read/write counters
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic [31:0] o_dmem_rdata,
  input  logic        i_err_clr,
  output logic        o_err,
  output logic [1:0]  o_err_cause,
`ifdef DMEM_RESPONDER_STATS_EN
  output logic [31:0] o_rd_count,
  output logic [31:0] o_wr_count,
`endif
  output logic [31:0] o_err_addr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] C_CAUSE_NONE  = 2'b00;
  localparam logic [1:0] C_CAUSE_BOTH  = 2'b01;
  localparam logic [1:0] C_CAUSE_RANGE = 2'b10;
  localparam logic [1:0] C_CAUSE_ALIGN = 2'b11;

  typedef enum logic [0:0] {
    ST_OK  = 1'b0,
    ST_ERR = 1'b1
  } state_t;

  logic [31:0]   mem [DEPTH_WORDS];

  state_t        state_q, state_d;
  logic [1:0]    err_cause_q, err_cause_d;
  logic [31:0]   err_addr_q, err_addr_d;

  logic [31:0]   w_off;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_cause;
  logic          w_viol;
  logic          w_rd_ok;
  logic          w_wr_ok;
  logic [31:0]   w_mask32;

  // Unsigned subtraction: an address below BASE_ADDR wraps to a huge offset,
  // but the explicit >= test is what rejects it.
  assign w_off      = i_dmem_addr - BASE_ADDR;
  assign w_in_range = (i_dmem_addr >= BASE_ADDR) &&
                      ({2'b00, w_off[31:2]} < 32'(DEPTH_WORDS));
  assign w_idx      = w_off[AW+1:2];

  // Violation cause, highest priority first; only meaningful with an enable.
  always_comb begin
    w_cause = C_CAUSE_NONE;
    if (i_dmem_ren || i_dmem_wen) begin
      if (i_dmem_ren && i_dmem_wen) begin
        w_cause = C_CAUSE_BOTH;
      end else if (!w_in_range) begin
        w_cause = C_CAUSE_RANGE;
      end else if (w_off[1:0] != 2'b00) begin
        // BASE_ADDR is word aligned, so the offset's low bits are the address's.
        w_cause = C_CAUSE_ALIGN;
      end
    end
  end

  assign w_viol  = (w_cause != C_CAUSE_NONE);
  assign w_rd_ok = i_dmem_ren && !w_viol;
  assign w_wr_ok = i_dmem_wen && !w_viol;

  assign w_mask32 = {{8{i_dmem_mask[3]}}, {8{i_dmem_mask[2]}},
                     {8{i_dmem_mask[1]}}, {8{i_dmem_mask[0]}}};

  assign o_dmem_rdata = w_rd_ok ? (mem[w_idx] & w_mask32) : 32'h0000_0000;

  // RAM has no reset. A write is dropped if reset is held at the edge, so the
  // target word only becomes undefined if reset races the edge itself.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_wr_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (i_dmem_mask[k]) begin
          mem[w_idx][8*k +: 8] <= i_dmem_wdata[8*k +: 8];
        end
      end
    end
  end

  // Sticky error capture FSM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_OK;
      err_cause_q <= C_CAUSE_NONE;
      err_addr_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      err_cause_q <= err_cause_d;
      err_addr_q  <= err_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    err_cause_d = err_cause_q;
    err_addr_d  = err_addr_q;
    case (state_q)
      ST_OK: begin
        if (w_viol) begin
          state_d     = ST_ERR;
          err_cause_d = w_cause;
          err_addr_d  = i_dmem_addr;
        end
      end
      ST_ERR: begin
        // Clear beats any coincident violation; otherwise hold the capture.
        if (i_err_clr) begin
          state_d     = ST_OK;
          err_cause_d = C_CAUSE_NONE;
          err_addr_d  = 32'h0000_0000;
        end
      end
      default: begin
        state_d     = ST_OK;
        err_cause_d = C_CAUSE_NONE;
        err_addr_d  = 32'h0000_0000;
      end
    endcase
  end

  assign o_err       = (state_q == ST_ERR);
  assign o_err_cause = err_cause_q;
  assign o_err_addr  = err_addr_q;

`ifdef DMEM_RESPONDER_STATS_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  // Zero-mask legal accesses still count; counters wrap naturally.
  assign rd_count_d = w_rd_ok ? rd_count_q + 32'd1 : rd_count_q;
  assign wr_count_d = w_wr_ok ? wr_count_q + 32'd1 : wr_count_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_count_q <= 32'h0000_0000;
      wr_count_q <= 32'h0000_0000;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign o_rd_count = rd_count_q;
  assign o_wr_count = wr_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Directed self-checking bench for dmem_responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic        ren;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic [31:0] rdata;
  logic        err_clr;
  logic        err;
  logic [1:0]  err_cause;
  logic [31:0] err_addr;
`ifdef DMEM_RESPONDER_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  int errors = 0;
  int checks = 0;

  dmem_responder #(
    .BASE_ADDR   (32'h0000_0000),
    .DEPTH_WORDS (1024)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_dmem_addr  (addr),
    .i_dmem_ren   (ren),
    .i_dmem_wen   (wen),
    .i_dmem_wdata (wdata),
    .i_dmem_mask  (mask),
    .o_dmem_rdata (rdata),
    .i_err_clr    (err_clr),
    .o_err        (err),
    .o_err_cause  (err_cause),
`ifdef DMEM_RESPONDER_STATS_EN
    .o_rd_count   (rd_count),
    .o_wr_count   (wr_count),
`endif
    .o_err_addr   (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m, input logic c);
    ren = r; wen = w; addr = a; wdata = d; mask = m; err_clr = c;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic chk_err(input string tag, input logic e, input logic [1:0] c,
                         input logic [31:0] a);
    chk({tag, "_err"},   {31'd0, err},       {31'd0, e});
    chk({tag, "_cause"}, {30'd0, err_cause}, {30'd0, c});
    chk({tag, "_addr"},  err_addr,           a);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    chk_err("reset", 1'b0, 2'b00, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
`ifdef DMEM_RESPONDER_STATS_EN
    chk("reset_rdcnt", rd_count, 32'h0);
    chk("reset_wrcnt", wr_count, 32'h0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Write/read at 0x10: prior value visible until the edge after the write.
    drive(1'b0, 1'b1, 32'h10, 32'h0102_0304, 4'hF, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
    chk("wr1_read", rdata, 32'h0102_0304);
    drive(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
    chk("wcycle_rdata", rdata, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
    chk("wr2_read", rdata, 32'hDEAD_BEEF);
    tick();

    // Byte/half-word lanes at 0x0.
    drive(1'b0, 1'b1, 32'h0, 32'h1122_3344, 4'hF, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h0, 32'hAA00_0000, 4'b1000, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'b0000, 1'b0);  // zero-mask write: no-op
    tick();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
    chk("lane_full", rdata, 32'hAA22_3344);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'b1100, 1'b0);
    chk("lane_hi", rdata, 32'hAA22_0000);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0);
    chk("lane_zero", rdata, 32'h0);
    chk_err("legal_ops", 1'b0, 2'b00, 32'h0);
    tick();

    // Simultaneous enables at 0x20.
    drive(1'b0, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h20, 32'h5, 4'hF, 1'b0);
    chk("both_rdata", rdata, 32'h0);
    tick();
    idle();
    chk_err("both", 1'b1, 2'b01, 32'h20);
    drive(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
    chk("both_ram", rdata, 32'h1234_5678);
    tick();

    // Sticky capture: out-of-range write in ERR is ignored and not captured.
    drive(1'b0, 1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0);
    chk("oor_rdata", rdata, 32'h0);
    tick();
    idle();
    chk_err("sticky", 1'b1, 2'b01, 32'h20);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
    chk("oor_nowrite", rdata, 32'hAA22_3344);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    tick();
    idle();
    chk_err("clear", 1'b0, 2'b00, 32'h0);

    // Out-of-range read from OK captures cause 10.
    drive(1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b0);
    tick();
    idle();
    chk_err("range", 1'b1, 2'b10, 32'h2000);

    // Unaligned read colliding with clear: clear wins.
    drive(1'b1, 1'b0, 32'h6, 32'h0, 4'hF, 1'b1);
    chk("unal_rdata", rdata, 32'h0);
    tick();
    chk_err("collide", 1'b0, 2'b00, 32'h0);
    drive(1'b1, 1'b0, 32'h6, 32'h0, 4'hF, 1'b0);
    tick();
    idle();
    chk_err("unaligned", 1'b1, 2'b11, 32'h6);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    tick();

    // Priority: out-of-range beats misalignment.
    drive(1'b0, 1'b1, 32'h1002, 32'h0, 4'hF, 1'b0);
    tick();
    idle();
    chk_err("prio", 1'b1, 2'b10, 32'h1002);

    // Async reset clears error immediately, and a write held across reset is dropped.
    drive(1'b0, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_err("async_rst", 1'b0, 2'b00, 32'h0);
    tick();
    idle();
    rst_n = 1'b1;
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
    chk("rst_abandon", rdata, 32'hDEAD_BEEF);
    tick();

`ifdef DMEM_RESPONDER_STATS_EN
    // Fresh counts: reset, then 3 legal reads (one zero-mask) and 2 legal writes.
    idle();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0);  tick();
    drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);  tick();
    drive(1'b0, 1'b1, 32'h8, 32'h9, 4'hF, 1'b0);  tick();
    drive(1'b1, 1'b1, 32'h8, 32'h9, 4'hF, 1'b0);  tick();  // illegal: not counted
    drive(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0);  tick();
    drive(1'b0, 1'b1, 32'hC, 32'h9, 4'h0, 1'b0);  tick();
    idle();
    chk("stats_rd", rd_count, 32'd3);
    chk("stats_wr", wr_count, 32'd2);
    chk("stats_err", {31'd0, err}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("stats_rd_rst", rd_count, 32'd0);
    chk("stats_wr_rst", wr_count, 32'd0);
    chk("stats_err_rst", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
